// File: rtl/display_mode_selector.sv
// display_mode_selector: debounced Next/Auto buttons driving the 2-bit mirror display selector with auto-scroll.
module display_mode_selector #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_W            = 20,
  parameter int unsigned DWELL_CYCLES    = 150000000,
  parameter int unsigned DW_W            = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Btn_Next,
  input  logic       Btn_Auto,
  output logic [1:0] SS,
  output logic       Auto_On,
  output logic       Mode_Change
);
  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_t;
  state_t                  state_q, state_d;
  logic [1:0]              sync1_q, sync2_q;
  logic [1:0]              db_q, db_d, dbp_q, flip, press;
  logic [1:0][DB_W-1:0]    cnt_q, cnt_d;
  logic [DW_W-1:0]         dwell_q, dwell_d;
  logic [1:0]              ss_q, ss_d;
  logic                    mc_q, mc_d;
  logic                    next_p, auto_p, expire, adv;
  // Bit 0 carries Next, bit 1 carries Auto; both buttons are debounced independently.
  always_comb begin
    flip  = '0;
    cnt_d = '0;
    for (int i = 0; i < 2; i++) begin
      flip[i]  = (sync2_q[i] != db_q[i]) && (cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1));
      cnt_d[i] = (sync2_q[i] != db_q[i]) && !flip[i] ? cnt_q[i] + 1'b1 : '0;
    end
    db_d = db_q ^ flip;
  end
  assign press  = db_q & ~dbp_q;
  assign next_p = press[0];
  assign auto_p = press[1];
  always_comb begin
    state_d = state_q;
    if (auto_p) state_d = (state_q == AUTO) ? MANUAL : AUTO;
    expire  = (state_q == AUTO) && (dwell_q == DW_W'(DWELL_CYCLES - 1));
    adv     = next_p | expire;
    dwell_d = (state_q == AUTO) && !auto_p && !adv ? dwell_q + 1'b1 : '0;
    ss_d    = adv ? ss_q + 2'd1 : ss_q;
    mc_d    = adv;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      db_q    <= '0;
      dbp_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      ss_q    <= '0;
      mc_q    <= 1'b0;
      state_q <= MANUAL;
    end else begin
      sync1_q <= {Btn_Auto, Btn_Next};
      sync2_q <= sync1_q;
      db_q    <= db_d;
      dbp_q   <= db_q;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      ss_q    <= ss_d;
      mc_q    <= mc_d;
      state_q <= state_d;
    end
  end
  assign SS          = ss_q;
  assign Auto_On     = (state_q == AUTO);
  assign Mode_Change = mc_q;
endmodule

// File: doc/display_mode_selector.md
Name: display_mode_selector

Overview:
Generates the 2-bit selector code SS that drives the mirror display multiplexer. SS 0 = Temperature, 1 = Average_mpg, 2 = Instantaneous_mpg, 3 = Miles_remaining. The driver steps SS manually with a debounced "Next" push button. A debounced "Auto" button toggles an auto-scroll mode, which advances SS after a fixed dwell time. The block sits directly upstream of the display multiplexer, and its SS output connects straight to the multiplexer's SS input.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a button level change (10 ms at 50 MHz); must be >= 1
DB_W, 20, width of the debounce counters; must hold DEBOUNCE_CYCLES
DWELL_CYCLES, 150000000, clocks per display item in auto-scroll (3 s at 50 MHz); must be >= 2
DW_W, 28, width of the dwell counter; must hold DWELL_CYCLES-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
Btn_Next  input  1  raw mechanical button, active-high, asynchronous to clk
Btn_Auto  input  1  raw mechanical button, active-high, asynchronous to clk
SS  output  2  display selector code to the mirror display mux
Auto_On  output  1  high while auto-scroll is enabled
Mode_Change  output  1  one-cycle pulse, high in the first cycle SS holds a new value

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values, applied asynchronously while rst_n = 0:
  - SS = 0, Auto_On = 0, Mode_Change = 0.
  - Synchronizer flops, debounced levels, debounce counters and dwell counter all = 0.
  - Assertion mid-operation (counting, mid-debounce) aborts it with no pending edge retained.
- Synchronizer: each button passes through a 2-flop synchronizer; nothing else samples the raw inputs.
- Debounce, per button:
  - Counter increments each clock that the synchronized level differs from the debounced level.
  - Counter clears to 0 on any clock where they match.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
- Edges: a press = debounced 0->1 transition. Releases (1->0) cause no action.
- Latency: a raw rise sampled at edge t0 gives debounced high at edge t0+1+DEBOUNCE_CYCLES and SS update at edge t0+2+DEBOUNCE_CYCLES.
- FSM states, encoded as Auto_On:
  - MANUAL -> AUTO on an Auto press.
  - AUTO -> MANUAL on an Auto press.
  - Dwell counter clears on every transition.
- Advance rule:
  - SS <= SS+1, modulo 4, so 3 wraps to 0.
  - Mode_Change <= 1 for exactly that cycle; otherwise Mode_Change <= 0.
- MANUAL:
  - A Next press advances SS.
  - Dwell counter held at 0.
- AUTO:
  - Dwell counter increments every clock.
  - At count DWELL_CYCLES-1 it wraps to 0 and SS advances, so SS holds each value for exactly DWELL_CYCLES clocks.
  - A Next press also advances SS and clears the dwell counter.
- Simultaneous events:
  - Next press and dwell expiry in the same cycle: SS advances by exactly 1 and the dwell counter restarts at 0.
  - Next press and Auto press in the same cycle: mode toggles, SS advances by 1, dwell counter = 0.
  - Both buttons are debounced independently; holding one does not block the other.
- Held buttons: a held Next produces one advance only, with no auto-repeat.
- Output timing: all outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and DWELL_CYCLES=10.
1. Reset: rst_n low for 3 cycles, then high with buttons low -> SS=0, Auto_On=0, Mode_Change=0. Drive rst_n low mid-count with SS=2 -> SS=0 immediately, without waiting for a clk edge.
2. Clean press: Btn_Next high for 20 cycles from edge t0 -> SS 0->1 at edge t0+6, Mode_Change high for exactly one cycle. Four such presses -> SS sequence 1,2,3,0. Releases produce no change.
3. Bounce: Btn_Next toggling high 3 cycles / low 1 cycle for 40 cycles -> SS unchanged, no Mode_Change. Then held high 10 cycles -> exactly one advance.
4. Auto-scroll: Auto press -> Auto_On=1, then SS advances every 10 clocks (0,1,2,3,0) with a Mode_Change pulse each time. A second Auto press -> Auto_On=0 and SS holds indefinitely.
5. Collision: in AUTO, time a Next press so its debounced edge lands on dwell count 9 -> SS advances by 1 only (e.g. 2->3), and the next auto advance occurs 10 clocks later.
6. Both buttons: Btn_Next and Btn_Auto rise on the same edge from MANUAL, SS=1 -> at edge t0+6, SS=2 and Auto_On=1; the next auto advance to SS=3 occurs 10 clocks later.
